// File: rtl/tm_clause_scheduler.sv
// Time-multiplexed Tsetlin Machine inference: one clause per cycle on a shared
// evaluator, signed per-class vote accumulation, argmax over a valid/ready output.
module tm_clause_scheduler #(
  parameter int N_FEAT   = 9,
  parameter int N_CLAUSE = 12,
  parameter int N_CLASS  = 3
) (
  input  logic                        clk1,
  input  logic                        rst,
  input  logic                        cfg_we,
  input  logic [$clog2(N_CLAUSE)-1:0] cfg_addr,
  input  logic [2*N_FEAT-1:0]         cfg_data,
  output logic                        cfg_err,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_FEAT-1:0]           features,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(N_CLASS)-1:0]  final_class,
  output logic                        busy
);
  localparam int AW  = $clog2(N_CLAUSE);
  localparam int CW  = $clog2(N_CLASS);
  localparam int LW  = 2*N_FEAT;
  localparam int CPC = N_CLAUSE/N_CLASS;
  localparam int VW  = $clog2(CPC)+2;

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_ARGMAX, S_DONE} state_t;

  state_t                          r_state;
  logic [N_CLAUSE-1:0][LW-1:0]     r_mask;
  logic [N_FEAT-1:0]               r_feat;
  logic [AW-1:0]                   r_idx;
  logic [N_CLASS-1:0][VW-1:0]      r_vote;
  logic [CW-1:0]                   r_cls;
  logic                            r_out_valid;
  logic                            r_cfg_err;

  logic          w_wr_ok;
  logic [LW-1:0] w_lit;
  logic [LW-1:0] w_cur_mask;
  logic          w_fire;
  logic [AW-1:0] w_sub;
  logic [CW-1:0] w_cls;
  logic          w_neg;
  logic [CW-1:0] w_best;
  logic [VW-1:0] w_best_v;

  // Address range is checked one bit wider so a power-of-two clause count still works.
  assign w_wr_ok    = cfg_we && (r_state == S_IDLE) &&
                      ({1'b0, cfg_addr} < (AW+1)'(N_CLAUSE));
  assign w_lit      = {r_feat, ~r_feat};
  assign w_cur_mask = r_mask[r_idx];
  assign w_fire     = (|w_cur_mask) && ((w_lit & w_cur_mask) == w_cur_mask);
  assign w_cls      = CW'(r_idx / AW'(CPC));
  assign w_sub      = r_idx % AW'(CPC);
  assign w_neg      = w_sub[0];

  // Strict greater-than keeps the lowest class index on ties.
  always_comb begin
    w_best   = '0;
    w_best_v = r_vote[0];
    for (int k = 1; k < N_CLASS; k++) begin
      if ($signed(r_vote[k]) > $signed(w_best_v)) begin
        w_best   = CW'(k);
        w_best_v = r_vote[k];
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_mask      <= '0;
      r_feat      <= '0;
      r_idx       <= '0;
      r_vote      <= '0;
      r_cls       <= '0;
      r_out_valid <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err <= cfg_we && !w_wr_ok;
      if (w_wr_ok) r_mask[cfg_addr] <= cfg_data;
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_feat  <= features;
          r_vote  <= '0;
          r_idx   <= '0;
          r_state <= S_EVAL;
        end
        S_EVAL: begin
          if (w_fire)
            r_vote[w_cls] <= w_neg ? r_vote[w_cls] - VW'(1) : r_vote[w_cls] + VW'(1);
          if (r_idx == AW'(N_CLAUSE-1)) begin
            r_idx   <= '0;
            r_state <= S_ARGMAX;
          end else begin
            r_idx <= r_idx + AW'(1);
          end
        end
        S_ARGMAX: begin
          r_cls       <= w_best;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cfg_err     = r_cfg_err;
  assign in_ready    = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign out_valid   = r_out_valid;
  assign final_class = r_cls;
endmodule

// File: tb/tb_tm_clause_scheduler.sv
// Randomized self-checking bench for tm_clause_scheduler against a vote-counting model.
module tb_tm_clause_scheduler;
  localparam int NF = 9, NC = 12, NK = 3, CPC = NC/NK, LAT = NC+1;

  logic        clk1 = 0, rst = 0, cfg_we = 0, in_valid = 0, out_ready = 0;
  logic [3:0]  cfg_addr = 0;
  logic [17:0] cfg_data = 0;
  logic [8:0]  features = 0;
  logic        cfg_err, in_ready, out_valid, busy;
  logic [1:0]  final_class;

  int vecs = 0, errs = 0;
  logic [17:0] mdl [NC];

  tm_clause_scheduler #(.N_FEAT(NF), .N_CLAUSE(NC), .N_CLASS(NK)) dut (
    .clk1(clk1), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready), .features(features),
    .out_valid(out_valid), .out_ready(out_ready), .final_class(final_class), .busy(busy));

  always #5 clk1 = ~clk1;

  task automatic tick(); @(posedge clk1); #1; endtask

  function automatic int ref_class(logic [8:0] f);
    int v[NK];
    int best;
    logic [17:0] lit, m;
    lit = {f, ~f};
    for (int k = 0; k < NK; k++) v[k] = 0;
    for (int c = 0; c < NC; c++) begin
      m = mdl[c];
      if (m != 0 && (lit & m) == m) v[c/CPC] += ((c%CPC)%2 == 1) ? -1 : 1;
    end
    best = 0;
    for (int k = 1; k < NK; k++) if (v[k] > v[best]) best = k;
    return best;
  endfunction

  task automatic clear_model(); for (int c = 0; c < NC; c++) mdl[c] = '0; endtask

  // Write in IDLE; the model only keeps in-range addresses.
  task automatic wr(input int a, input logic [17:0] d);
    cfg_we = 1; cfg_addr = a[3:0]; cfg_data = d;
    tick();
    cfg_we = 0;
    if (a < NC) mdl[a] = d;
  endtask

  task automatic sample(input logic [8:0] f, input int hold, output int lat, output int cls);
    in_valid = 1; features = f;
    tick();
    in_valid = 0; features = 9'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    cls = int'(final_class);
    repeat (hold) tick();
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic test_reset();
    int lat, cls;
    rst = 0; in_valid = 1; cfg_we = 1; cfg_addr = 1; cfg_data = 18'h00001;
    repeat (2) tick();
    rst = 1; in_valid = 0; cfg_we = 0;
    clear_model();
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    vecs++; if (final_class !== 2'd0) begin errs++; $display("FAIL reset_final_class got %0d want 0", final_class); end
    vecs++; if (cfg_err !== 1'b0) begin errs++; $display("FAIL reset_cfg_err got %0b want 0", cfg_err); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %0b want 0", busy); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    sample(9'd0, 0, lat, cls);
    vecs++; if (lat !== LAT) begin errs++; $display("FAIL reset_latency got %0d want %0d", lat, LAT); end
    vecs++; if (cls !== ref_class(9'd0)) begin errs++; $display("FAIL reset_no_write got %0d want %0d", cls, ref_class(9'd0)); end
  endtask

  task automatic test_positive();
    int lat, cls;
    wr(4, 18'h00200);
    sample(9'b000000001, 0, lat, cls);
    vecs++; if (lat !== LAT) begin errs++; $display("FAIL pos_latency got %0d want %0d", lat, LAT); end
    vecs++; if (cls !== ref_class(9'd1)) begin errs++; $display("FAIL pos_class got %0d want %0d", cls, ref_class(9'd1)); end
  endtask

  task automatic test_negative_tie();
    int lat, cls;
    logic [8:0] f;
    wr(4, 18'h0); wr(1, 18'h00001);
    sample(9'd0, 0, lat, cls);
    vecs++; if (cls !== ref_class(9'd0)) begin errs++; $display("FAIL neg_tie_class got %0d want %0d", cls, ref_class(9'd0)); end
    wr(1, 18'h0);
    f = 9'($urandom);
    sample(f, 0, lat, cls);
    vecs++; if (cls !== ref_class(f)) begin errs++; $display("FAIL empty_class got %0d want %0d", cls, ref_class(f)); end
  endtask

  task automatic test_backpressure();
    int n;
    wr(4, 18'h00200);
    in_valid = 1; features = 9'd1;
    tick();
    in_valid = 0; features = 9'h1FE;
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    vecs++; if (n !== LAT) begin errs++; $display("FAIL bp_latency got %0d want %0d", n, LAT); end
    for (int i = 0; i < 5; i++) begin
      tick();
      vecs++; if (final_class !== 2'(ref_class(9'd1))) begin errs++; $display("FAIL bp_hold_class got %0d want %0d", final_class, ref_class(9'd1)); end
      vecs++; if ({out_valid, in_ready, busy} !== 3'b101) begin errs++; $display("FAIL bp_hold_flags got %b want 101", {out_valid, in_ready, busy}); end
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    vecs++; if ({out_valid, in_ready, busy} !== 3'b010) begin errs++; $display("FAIL bp_release_flags got %b want 010", {out_valid, in_ready, busy}); end
  endtask

  task automatic test_rejected();
    int n, lat, cls;
    in_valid = 1; features = 9'd1;
    tick();
    in_valid = 0;
    repeat (3) tick();
    cfg_we = 1; cfg_addr = 4; cfg_data = 18'h0;
    tick();
    cfg_we = 0;
    vecs++; if (cfg_err !== 1'b1) begin errs++; $display("FAIL rej_eval_err got %0b want 1", cfg_err); end
    tick();
    vecs++; if (cfg_err !== 1'b0) begin errs++; $display("FAIL rej_eval_pulse got %0b want 0", cfg_err); end
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    vecs++; if (final_class !== 2'(ref_class(9'd1))) begin errs++; $display("FAIL rej_eval_class got %0d want %0d", final_class, ref_class(9'd1)); end
    out_ready = 1; tick(); out_ready = 0;
    cfg_we = 1; cfg_addr = 12; cfg_data = 18'h3FFFF;
    tick();
    cfg_we = 0;
    vecs++; if (cfg_err !== 1'b1) begin errs++; $display("FAIL rej_addr_err got %0b want 1", cfg_err); end
    tick();
    vecs++; if (cfg_err !== 1'b0) begin errs++; $display("FAIL rej_addr_pulse got %0b want 0", cfg_err); end
    wr(2, 18'h0);
    vecs++; if (cfg_err !== 1'b0) begin errs++; $display("FAIL ok_write_err got %0b want 0", cfg_err); end
    sample(9'd1, 0, lat, cls);
    vecs++; if (cls !== ref_class(9'd1)) begin errs++; $display("FAIL rej_bank_class got %0d want %0d", cls, ref_class(9'd1)); end
  endtask

  task automatic test_same_cycle();
    int n, cls;
    cfg_we = 1; cfg_addr = 8; cfg_data = 18'h20000;
    in_valid = 1; features = 9'h100;
    tick();
    cfg_we = 0; in_valid = 0;
    mdl[8] = 18'h20000;
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    cls = int'(final_class);
    vecs++; if (cls !== ref_class(9'h100)) begin errs++; $display("FAIL same_cycle_class got %0d want %0d", cls, ref_class(9'h100)); end
    out_ready = 1; tick(); out_ready = 0;
    wr(8, 18'h0);
  endtask

  task automatic test_back_to_back();
    int n;
    in_valid = 1; out_ready = 1; features = 9'd1;
    tick();
    n = 0;
    while (busy && n < 100) begin tick(); n++; end
    vecs++; if (n !== NC+2) begin errs++; $display("FAIL b2b_busy_len got %0d want %0d", n, NC+2); end
    tick();
    in_valid = 0;
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL b2b_second_accept got %0b want 1", busy); end
    n = 0;
    while (busy && n < 100) begin tick(); n++; end
    out_ready = 0;
  endtask

  task automatic test_reset_mid();
    int lat, cls;
    wr(4, 18'h00200);
    in_valid = 1; features = 9'd1;
    tick();
    in_valid = 0;
    repeat (6) tick();
    rst = 0;
    tick();
    rst = 1;
    clear_model();
    vecs++; if ({out_valid, in_ready, busy} !== 3'b010) begin errs++; $display("FAIL mid_reset_flags got %b want 010", {out_valid, in_ready, busy}); end
    sample(9'd1, 0, lat, cls);
    vecs++; if (lat !== LAT) begin errs++; $display("FAIL mid_reset_latency got %0d want %0d", lat, LAT); end
    vecs++; if (cls !== ref_class(9'd1)) begin errs++; $display("FAIL mid_reset_class got %0d want %0d", cls, ref_class(9'd1)); end
  endtask

  task automatic test_random();
    int lat, cls, a, want;
    logic [17:0] d;
    logic [8:0] f;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) < 6) begin
        a = $urandom_range(0, 15);
        d = 18'($urandom & $urandom);
        d[8:0] = d[8:0] & ~d[17:9];
        wr(a, d);
        vecs++; if (cfg_err !== (a >= NC)) begin errs++; $display("FAIL rnd_cfg_err addr %0d got %0b want %0b", a, cfg_err, a >= NC); end
      end
      f = 9'($urandom);
      want = ref_class(f);
      sample(f, $urandom_range(0, 3), lat, cls);
      vecs++; if (lat !== LAT) begin errs++; $display("FAIL rnd_latency it %0d got %0d want %0d", it, lat, LAT); end
      vecs++; if (cls !== want) begin errs++; $display("FAIL rnd_class it %0d feat %h got %0d want %0d", it, f, cls, want); end
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_positive();
    test_negative_tie();
    test_backpressure();
    test_rejected();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
